mem_addr_arbiter: RTL and testbench

- Parametrised successor to the processor's two-way PC/operand address select.
- Arbitrates NUM_SRC requesters (default 2: index 0 = PC fetch, index 1 = operand access) for the single memory address port.
- Captures the winning address into a register and holds it under a valid/ready handshake until memory accepts it.
- Selectable fixed-priority or round-robin policy; optional timeout abort.

---
 rtl/mem_addr_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_addr_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_addr_arbiter.sv
// Arbitrates NUM_SRC requesters for one memory address port. The winning address
// is registered and held under a valid/ready handshake, with an optional timeout abort.
module mem_addr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2,
    parameter int RR_MODE    = 0,
    parameter int TIMEOUT    = 0,
    localparam int ID_WIDTH  = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_SRC-1:0]            ack,
    output logic [ID_WIDTH-1:0]           gnt_id,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          busy,
    output logic                          timeout_err
);

    // Wait counter only has to reach TIMEOUT-1; the abort fires on the next miss.
    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t                state, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  wait_cnt, wait_cnt_d;
    logic [ID_WIDTH-1:0]   winner, gnt_id_d;
    logic [ADDR_WIDTH-1:0] win_addr, mem_addr_d;
    logic [NUM_SRC-1:0]    ack_d;
    logic                  terr_d;

    // Winner search: scan upward from the pointer (0 in fixed-priority mode), wrapping.
    always_comb begin
        int                  idx;
        logic                found;
        logic [ID_WIDTH-1:0] sel;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        idx      = 0;
        found    = 1'b0;
        sel      = '0;
        winner   = '0;
        win_addr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            sel = ID_WIDTH'(idx);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (winner == ID_WIDTH'(k)) win_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        wait_cnt_d = wait_cnt;
        gnt_id_d   = gnt_id;
        mem_addr_d = mem_addr;
        ack_d      = '0;
        terr_d     = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d    = ISSUE;
                    gnt_id_d   = winner;
                    mem_addr_d = win_addr;
                    wait_cnt_d = '0;
                    if (RR_MODE != 0) begin
                        rr_ptr_d = (winner == ID_WIDTH'(NUM_SRC - 1)) ? '0 : winner + ID_WIDTH'(1);
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    // Ready on the final wait cycle still counts as completion.
                    state_d = IDLE;
                    ack_d   = NUM_SRC'(1) << gnt_id;
                end else if (TIMEOUT > 0 && wait_cnt == CNT_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else if (TIMEOUT > 0) begin
                    wait_cnt_d = wait_cnt + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            gnt_id      <= '0;
            mem_addr    <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            wait_cnt    <= wait_cnt_d;
            gnt_id      <= gnt_id_d;
            mem_addr    <= mem_addr_d;
            ack         <= ack_d;
            timeout_err <= terr_d;
        end
    end

    // Valid and busy both mean "transaction in flight", straight from the state flop.
    assign mem_valid = (state == ISSUE);
    assign busy      = (state == ISSUE);

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Bench for mem_addr_arbiter: a 2-source fixed-priority instance and a 4-source round-robin
// instance with timeout, checked by a transaction-level model feeding per-instance scoreboards.
module tb_mem_addr_arbiter;

    localparam int AW = 5;

    typedef enum int {EV_GRANT, EV_ACK, EV_TERR} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        int            id;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    int  total = 0;
    int  bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      req_a  = '0;
    logic [2*AW-1:0] addr_a = '0;
    logic            rdy_a  = 1'b0;
    logic [1:0]      ack_a;
    logic            gnt_a;
    logic [AW-1:0]   maddr_a;
    logic            valid_a, busy_a, terr_a;

    logic [3:0]      req_b  = '0;
    logic [4*AW-1:0] addr_b = '0;
    logic            rdy_b  = 1'b0;
    logic [3:0]      ack_b;
    logic [1:0]      gnt_b;
    logic [AW-1:0]   maddr_b;
    logic            valid_b, busy_b, terr_b;

    mem_addr_arbiter #(.ADDR_WIDTH(AW), .NUM_SRC(2), .RR_MODE(0), .TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_addr(addr_a), .ack(ack_a), .gnt_id(gnt_a),
        .mem_addr(maddr_a), .mem_valid(valid_a), .mem_ready(rdy_a), .busy(busy_a),
        .timeout_err(terr_a)
    );

    mem_addr_arbiter #(.ADDR_WIDTH(AW), .NUM_SRC(4), .RR_MODE(1), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_addr(addr_b), .ack(ack_b), .gnt_id(gnt_b),
        .mem_addr(maddr_b), .mem_valid(valid_b), .mem_ready(rdy_b), .busy(busy_b),
        .timeout_err(terr_b)
    );

    // Configuration of the two instances as seen by the model.
    int nsrc[2] = '{2, 4};
    int rrm[2]  = '{0, 1};
    int tmo[2]  = '{0, 3};

    // Next-cycle stimulus, applied by tick() and fed to the model at the same time.
    logic [3:0]    nx_req[2];
    logic [AW-1:0] nx_addr[2][4];
    logic          nx_rdy[2];
    logic          nx_rst;

    // Transaction model: owner of the open transaction (-1 none), misses so far, RR pointer.
    int owner[2], waited[2], ptr[2], done_src[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_ev(input int k, input ev_kind_t kind, input int id,
                                    input logic [AW-1:0] addr);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.addr = addr;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic bit pop_ev(input int k, output ev_t e);
        e = '{EV_GRANT, -1, '0};
        if (k == 0) begin
            if (q0.size() == 0) return 1'b0;
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) return 1'b0;
            e = q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]    = -1;
            waited[k]   = 0;
            ptr[k]      = 0;
            done_src[k] = -1;
        end
        q0.delete();
        q1.delete();
    endfunction

    // One clock edge of instance k, at transaction level.
    function automatic void model_step(input int k);
        int w;
        done_src[k] = -1;
        if (owner[k] < 0) begin
            w = -1;
            for (int j = 0; j < nsrc[k]; j++) begin
                int s;
                s = (rrm[k] != 0) ? (ptr[k] + j) % nsrc[k] : j;
                if (w < 0 && nx_req[k][s]) w = s;
            end
            if (w >= 0) begin
                push_ev(k, EV_GRANT, w, nx_addr[k][w]);
                owner[k]  = w;
                waited[k] = 0;
                if (rrm[k] != 0) ptr[k] = (w + 1) % nsrc[k];
            end
        end else if (nx_rdy[k]) begin
            push_ev(k, EV_ACK, owner[k], '0);
            done_src[k] = owner[k];
            owner[k]    = -1;
        end else begin
            waited[k]++;
            if (tmo[k] > 0 && waited[k] == tmo[k]) begin
                push_ev(k, EV_TERR, owner[k], '0);
                done_src[k] = owner[k];
                owner[k]    = -1;
            end
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
        rst    = nx_rst;
        req_a  = nx_req[0][1:0];
        addr_a = {nx_addr[0][1], nx_addr[0][0]};
        rdy_a  = nx_rdy[0];
        req_b  = nx_req[1];
        addr_b = {nx_addr[1][3], nx_addr[1][2], nx_addr[1][1], nx_addr[1][0]};
        rdy_b  = nx_rdy[1];
        if (nx_rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: compares every DUT-presented event with the model's queue.
    logic          prev_v[2]   = '{1'b0, 1'b0};
    logic [AW-1:0] cur_addr[2] = '{'0, '0};
    int            cur_gnt[2]  = '{0, 0};

    task automatic mon(input int k, input logic v, input int g, input logic [AW-1:0] a,
                       input logic [3:0] ackv, input logic terr, input logic bsy);
        ev_t   e;
        bit    ok;
        string tag;
        tag = (k == 0) ? "a" : "b";
        check({tag, "_busy_eq_valid"}, bsy, v);
        if (terr === 1'b1) begin
            ok = pop_ev(k, e);
            check({tag, "_terr_expected"}, ok, 1);
            if (ok) check({tag, "_terr_kind"}, e.kind, EV_TERR);
        end
        if (ackv !== 4'b0000) begin
            ok = pop_ev(k, e);
            check({tag, "_ack_expected"}, ok, 1);
            if (ok) begin
                check({tag, "_ack_kind"}, e.kind, EV_ACK);
                check({tag, "_ack_onehot"}, ackv, 32'(1) << e.id);
            end
        end
        if (v === 1'b1 && !prev_v[k]) begin
            ok = pop_ev(k, e);
            check({tag, "_grant_expected"}, ok, 1);
            if (ok) begin
                check({tag, "_grant_kind"}, e.kind, EV_GRANT);
                check({tag, "_grant_id"}, g, e.id);
                check({tag, "_grant_addr"}, a, e.addr);
                cur_addr[k] = e.addr;
                cur_gnt[k]  = e.id;
            end
        end else if (v === 1'b1) begin
            check({tag, "_hold_addr"}, a, cur_addr[k]);
            check({tag, "_hold_gnt"}, g, cur_gnt[k]);
        end
        prev_v[k] = v;
    endtask

    always @(negedge clk) begin
        mon(0, valid_a, int'(gnt_a), maddr_a, {2'b00, ack_a}, terr_a, busy_a);
        mon(1, valid_b, int'(gnt_b), maddr_b, ack_b, terr_b, busy_b);
    end

    int rr_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        nx_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            nx_req[k] = '0;
            nx_rdy[k] = 1'b0;
            for (int i = 0; i < 4; i++) nx_addr[k][i] = '0;
        end
        model_reset();

        // Reset held with both sources requesting: every output stays at zero.
        nx_req[0]     = 4'b0011;
        nx_addr[0][0] = 5'h04;
        nx_addr[0][1] = 5'h1A;
        nx_rdy[0]     = 1'b1;
        repeat (3) begin
            tick();
            settle();
            check("rst_valid", valid_a, 0);
            check("rst_addr", maddr_a, 0);
            check("rst_gnt", gnt_a, 0);
            check("rst_ack", ack_a, 0);
            check("rst_busy", busy_a, 0);
            check("rst_terr", terr_a, 0);
            check("rst_valid_b", valid_b, 0);
        end
        nx_rst = 1'b0;
        tick();
        settle();
        check("rel_valid", valid_a, 1);
        check("rel_gnt", gnt_a, 0);
        check("fp_addr0", maddr_a, 5'h04);

        // Fixed priority: source 0 first, then source 1 once 0 drops.
        tick();
        settle();
        check("fp_ack0", ack_a, 2'b01);
        nx_req[0] = 4'b0010;
        tick();
        settle();
        check("fp_addr1", maddr_a, 5'h1A);
        check("fp_gnt1", gnt_a, 1);
        tick();
        settle();
        check("fp_ack1", ack_a, 2'b10);
        nx_req[0] = '0;
        nx_rdy[0] = 1'b0;
        tick();

        // Wait states: captured address holds while req_addr moves.
        nx_req[0]     = 4'b0010;
        nx_addr[0][1] = 5'h11;
        tick();
        settle();
        check("ws_addr", maddr_a, 5'h11);
        nx_addr[0][1] = 5'h05;
        repeat (4) begin
            tick();
            settle();
            check("ws_hold_addr", maddr_a, 5'h11);
            check("ws_hold_valid", valid_a, 1);
            check("ws_no_ack", ack_a, 0);
        end
        nx_rdy[0] = 1'b1;
        tick();
        settle();
        check("ws_ack", ack_a, 2'b10);
        check("ws_busy", busy_a, 0);
        nx_req[0] = '0;
        nx_rdy[0] = 1'b0;
        tick();
        settle();
        check("ws_ack_pulse", ack_a, 0);
        check("ws_idle_valid", valid_a, 0);

        // Round-robin with all four sources requesting continuously.
        nx_req[1] = 4'b1111;
        nx_rdy[1] = 1'b1;
        for (int i = 0; i < 4; i++) nx_addr[1][i] = AW'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("rr_gnt", gnt_b, rr_seq[i]);
            check("rr_valid", valid_b, 1);
            tick();
            settle();
            check("rr_ack", ack_b, 32'(1) << rr_seq[i]);
        end
        nx_req[1] = '0;
        nx_rdy[1] = 1'b0;
        tick();

        // Timeout after three ready-less ISSUE cycles, then completion on the third.
        nx_req[1] = 4'b0100;
        tick();
        settle();
        check("to_valid", valid_b, 1);
        check("to_gnt", gnt_b, 2);
        repeat (2) begin
            tick();
            settle();
            check("to_wait_valid", valid_b, 1);
            check("to_wait_err", terr_b, 0);
        end
        tick();
        settle();
        check("to_err", terr_b, 1);
        check("to_err_valid", valid_b, 0);
        check("to_no_ack", ack_b, 0);
        tick();
        settle();
        check("to_err_pulse", terr_b, 0);
        check("to_regrant", valid_b, 1);
        check("to_regrant_gnt", gnt_b, 2);
        tick();
        tick();
        nx_rdy[1] = 1'b1;
        tick();
        settle();
        check("to_late_ack", ack_b, 4'b0100);
        check("to_late_err", terr_b, 0);
        nx_req[1] = '0;
        nx_rdy[1] = 1'b0;
        tick();

        // Asynchronous reset in the middle of a transaction.
        nx_req[1] = 4'b1111;
        tick();
        settle();
        check("ar_gnt_before", gnt_b, 3);
        tick();
        #2;
        rst    = 1'b1;
        nx_rst = 1'b1;
        model_reset();
        #1;
        check("ar_valid", valid_b, 0);
        check("ar_busy", busy_b, 0);
        check("ar_addr", maddr_b, 0);
        tick();
        settle();
        check("ar_no_ack", ack_b, 0);
        check("ar_no_err", terr_b, 0);
        nx_rst = 1'b0;
        tick();
        settle();
        check("ar_ptr_gnt", gnt_b, 0);
        check("ar_regrant", valid_b, 1);
        nx_rdy[1] = 1'b1;
        tick();
        nx_req[1] = '0;
        tick();
        nx_rdy[1] = 1'b0;

        // Randomized traffic on both instances.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nsrc[k]; i++) begin
                    if (!nx_req[k][i]) begin
                        if ($urandom_range(2) == 0) begin
                            nx_req[k][i]  = 1'b1;
                            nx_addr[k][i] = AW'($urandom);
                        end
                    end else if (done_src[k] == i) begin
                        if ($urandom_range(1) == 0) nx_req[k][i] = 1'b0;
                    end else if (owner[k] == i) begin
                        nx_addr[k][i] = AW'($urandom);
                        if ($urandom_range(15) == 0) nx_req[k][i] = 1'b0;
                    end
                end
                nx_rdy[k] = ($urandom_range(2) == 0);
            end
            tick();
        end

        // Drain and confirm every modelled event was presented.
        for (int k = 0; k < 2; k++) begin
            nx_req[k] = '0;
            nx_rdy[k] = 1'b1;
        end
        repeat (6) tick();
        @(negedge clk);
        #1;
        check("a_queue_drained", q0.size(), 0);
        check("b_queue_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
